// File: rtl/lookahead_coeff_loader_pkg.sv
// Shared types and helpers for the lookahead coefficient loader.
// Used by lookahead_coeff_loader and lookahead_coeff_bank.
package lookahead_pkg;

    localparam int unsigned NUM_COEF = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        FLUSH,
        RUN
    } state_t;

    typedef enum logic [3:0] {
        B0, B1, B2, B3, B4, B5, B6, A3, A6
    } coef_idx_t;

    function automatic int unsigned beats_per_coef(input int unsigned width, input int unsigned bus_w);
        return width / bus_w;
    endfunction

endpackage

// File: rtl/lookahead_coeff_bank.sv
// Shadow/active coefficient storage: chunk-wide writes into the shadow bank,
// and a commit strobe that copies the shadow (including a same-cycle write) to the active bank.
module lookahead_coeff_bank
    import lookahead_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BUS_W = 16,
    parameter int unsigned CW    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en_i,
    input  logic [3:0]                         wr_coef_i,
    input  logic [CW-1:0]                      wr_chunk_i,
    input  logic [BUS_W-1:0]                   wr_data_i,
    input  logic                               commit_i,
    output logic [NUM_COEF-1:0][WIDTH-1:0]     active_o
);

    localparam int unsigned BPC = beats_per_coef(WIDTH, BUS_W);

    logic [NUM_COEF-1:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_COEF-1:0][WIDTH-1:0] active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            for (int unsigned c = 0; c < NUM_COEF; c++) begin
                for (int unsigned k = 0; k < BPC; k++) begin
                    if (wr_coef_i == 4'(c) && wr_chunk_i == CW'(k)) begin
                        shadow_d[c][k*BUS_W +: BUS_W] = wr_data_i;
                    end
                end
            end
        end
    end

    // Commit takes shadow_d so the final beat of a load lands in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (commit_i) begin
                active_q <= shadow_d;
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/lookahead_coeff_loader.sv
// Coefficient loader for lookahead_structural: config-bus assembly, atomic commit, flush and sample strobe.
// Optional checksum beat enabled by defining LOOKAHEAD_COEFF_CHECKSUM_EN.
module lookahead_coeff_loader
    import lookahead_pkg::*;
#(
    parameter int unsigned WHOLE_BITS = 10,
    parameter int unsigned FRAC_BITS  = 54,
    parameter int unsigned WIDTH      = WHOLE_BITS + FRAC_BITS,
    parameter int unsigned BUS_W      = 16,
    parameter int unsigned FLUSH_CYC  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [BUS_W-1:0] cfg_data,
    output logic             cfg_ready,
    output logic             load_done,
    output logic             load_err,
    input  logic             adc_strobe,
    output logic             sample_ready,
    output logic             coefficients_ready,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] b2,
    output logic [WIDTH-1:0] b3,
    output logic [WIDTH-1:0] b4,
    output logic [WIDTH-1:0] b5,
    output logic [WIDTH-1:0] b6,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] a6
);

    localparam int unsigned BPC = beats_per_coef(WIDTH, BUS_W);
    localparam int unsigned CW  = (BPC > 1) ? $clog2(BPC) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] chunk_q, chunk_d;
    logic [3:0]    coef_q, coef_d;
    logic [7:0]    flush_q, flush_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          strobe_q;
    logic          sample_q;
    logic          wr_en;
    logic          commit;
    logic          beat;
    logic          last_beat;
    logic          load_start;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
    logic [BUS_W-1:0] xor_q, xor_d;
    logic             err_q, err_d;
`endif

    logic [NUM_COEF-1:0][WIDTH-1:0] active;

    assign cfg_ready  = (state_q == LOAD) || (state_q == CHECK);
    assign beat       = cfg_valid && cfg_ready;
    assign last_beat  = (coef_q == A6) && (chunk_q == CW'(BPC - 1));
    assign load_start = cfg_start && (state_q == IDLE || state_q == LOAD || state_q == RUN);

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        coef_d  = coef_q;
        flush_d = flush_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            LOAD: begin
                if (beat && !cfg_start) begin
                    wr_en = 1'b1;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
                    xor_d = xor_q ^ cfg_data;
`endif
                    if (last_beat) begin
                        chunk_d = '0;
                        coef_d  = '0;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
                        state_d = CHECK;
`else
                        commit  = 1'b1;
                        done_d  = 1'b1;
                        ready_d = 1'b0;
                        flush_d = 8'(FLUSH_CYC - 1);
                        state_d = FLUSH;
`endif
                    end else if (chunk_q == CW'(BPC - 1)) begin
                        chunk_d = '0;
                        coef_d  = coef_q + 4'd1;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                    end
                end
            end
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
            CHECK: begin
                if (beat) begin
                    if (cfg_data == xor_q) begin
                        commit  = 1'b1;
                        done_d  = 1'b1;
                        ready_d = 1'b0;
                        flush_d = 8'(FLUSH_CYC - 1);
                        state_d = FLUSH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ready_q ? RUN : IDLE;
                    end
                end
            end
`endif
            FLUSH: begin
                if (flush_q == '0) begin
                    ready_d = 1'b1;
                    state_d = RUN;
                end else begin
                    flush_d = flush_q - 8'd1;
                end
            end
            default: ;
        endcase

        // A (re)start overrides any same-cycle beat handling above.
        if (load_start) begin
            state_d = LOAD;
            chunk_d = '0;
            coef_d  = '0;
            wr_en   = 1'b0;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
            xor_d   = '0;
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            chunk_q  <= '0;
            coef_q   <= '0;
            flush_q  <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            sample_q <= 1'b0;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
            xor_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            chunk_q  <= chunk_d;
            coef_q   <= coef_d;
            flush_q  <= flush_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            strobe_q <= adc_strobe;
            sample_q <= (state_q == RUN) && adc_strobe && !strobe_q;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
            xor_q    <= xor_d;
            err_q    <= err_d;
`endif
        end
    end

    lookahead_coeff_bank #(
        .WIDTH (WIDTH),
        .BUS_W (BUS_W),
        .CW    (CW)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (wr_en),
        .wr_coef_i  (coef_q),
        .wr_chunk_i (chunk_q),
        .wr_data_i  (cfg_data),
        .commit_i   (commit),
        .active_o   (active)
    );

    assign load_done          = done_q;
    assign sample_ready       = sample_q;
    assign coefficients_ready = ready_q;
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
    assign load_err           = err_q;
`else
    assign load_err           = 1'b0;
`endif

    assign b0 = active[B0];
    assign b1 = active[B1];
    assign b2 = active[B2];
    assign b3 = active[B3];
    assign b4 = active[B4];
    assign b5 = active[B5];
    assign b6 = active[B6];
    assign a3 = active[A3];
    assign a6 = active[A6];

endmodule

// File: tb/tb_lookahead_coeff_loader.sv
// Directed bench for lookahead_coeff_loader: table-driven loads and strobe patterns,
// plus hand sequences for restart, checksum error and mid-load reset.
module tb_lookahead_coeff_loader;

    localparam int unsigned TOTAL = 36;

    typedef logic [63:0] coef_arr_t [9];

    typedef struct {
        string     name;
        bit        gap;
        bit        hold;
        logic [63:0] old_b0;
        coef_arr_t c;
    } load_vec_t;

    typedef struct {
        string       name;
        int unsigned len;
        logic [31:0] s;
        logic [31:0] e;
    } strobe_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic        cfg_valid;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic        load_done;
    logic        load_err;
    logic        adc_strobe;
    logic        sample_ready;
    logic        coefficients_ready;
    logic [63:0] b0, b1, b2, b3, b4, b5, b6, a3, a6;

    int total = 0;
    int bad   = 0;

    lookahead_coeff_loader dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_start          (cfg_start),
        .cfg_valid          (cfg_valid),
        .cfg_data           (cfg_data),
        .cfg_ready          (cfg_ready),
        .load_done          (load_done),
        .load_err           (load_err),
        .adc_strobe         (adc_strobe),
        .sample_ready       (sample_ready),
        .coefficients_ready (coefficients_ready),
        .b0 (b0), .b1 (b1), .b2 (b2), .b3 (b3), .b4 (b4),
        .b5 (b5), .b6 (b6), .a3 (a3), .a6 (a6)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] get_b(input int i);
        case (i)
            0: return b0;
            1: return b1;
            2: return b2;
            3: return b3;
            4: return b4;
            5: return b5;
            6: return b6;
            7: return a3;
            default: return a6;
        endcase
    endfunction

    task automatic check_bank(input string name, input coef_arr_t c);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_coef%0d", name, i), get_b(i), c[i]);
        end
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 16'h0000;
    endtask

    // Sends all beats of a bank (plus checksum when enabled) and checks the commit and flush window.
    task automatic send_row(input string name, input coef_arr_t c, input bit gap,
                            input bit hold, input logic [63:0] old_b0);
        logic [15:0] x;
        logic [63:0] w;
        x = 16'h0000;
        for (int k = 0; k < TOTAL; k++) begin
            if (gap && (k % 2 == 1)) begin
                cfg_valid = 1'b0;
                cfg_data  = 16'hDEAD;
                tick();
            end
            if (k == TOTAL - 1) begin
                check({name, "_hold_ready"}, 64'(coefficients_ready), 64'(hold));
                check({name, "_hold_b0"}, b0, old_b0);
                check({name, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
            end
            w = c[k / 4];
            x = x ^ w[16*(k%4) +: 16];
            send_beat(w[16*(k%4) +: 16]);
        end
`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
        send_beat(x);
`endif
        check({name, "_done"}, 64'(load_done), 64'd1);
        check({name, "_flush_ready0"}, 64'(coefficients_ready), 64'd0);
        check_bank(name, c);
        for (int i = 1; i < 4; i++) begin
            adc_strobe = 1'(i % 2);
            tick();
            check($sformatf("%s_flush%0d_ready", name, i), 64'(coefficients_ready), 64'd0);
            check($sformatf("%s_flush%0d_done", name, i), 64'(load_done), 64'd0);
            check($sformatf("%s_flush%0d_sample", name, i), 64'(sample_ready), 64'd0);
        end
        adc_strobe = 1'b0;
        tick();
        check({name, "_run_ready"}, 64'(coefficients_ready), 64'd1);
        check({name, "_run_sample"}, 64'(sample_ready), 64'd0);
    endtask

    load_vec_t   lvec [2];
    strobe_vec_t svec [3];
    coef_arr_t   row2;

    initial begin
        lvec[0] = '{name: "load_idle", gap: 1'b0, hold: 1'b0, old_b0: 64'h0,
                    c: '{64'h0040_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0,
                         64'h0, 64'h0, 64'h0, 64'h0}};
        lvec[1] = '{name: "reload_gap", gap: 1'b1, hold: 1'b1, old_b0: 64'h0040_0000_0000_0000,
                    c: '{64'h0020_0000_0000_0000, 64'h1111_2222_3333_4444,
                         64'hA5A5_5A5A_0F0F_F0F0, 64'h0000_0000_0000_0001,
                         64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'h003F_FFFF_FFFF_FFFF}};
        row2 = '{64'h0, 64'h0040_0000_0000_0000, 64'hDEAD_BEEF_CAFE_F00D,
                 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 64'h6};

        // Strobe bits are LSB-first per cycle; expected pulse = rise seen on that cycle.
        svec[0] = '{name: "hold5x3", len: 24, s: 32'h001F_1F1F, e: 32'h0001_0101};
        svec[1] = '{name: "toggle",  len: 8,  s: 32'h0000_0055, e: 32'h0000_0055};
        svec[2] = '{name: "late",    len: 8,  s: 32'h0000_00FE, e: 32'h0000_0002};

        reset      = 1'b1;
        cfg_start  = 1'b0;
        cfg_valid  = 1'b0;
        cfg_data   = 16'h0000;
        adc_strobe = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_coef_ready", 64'(coefficients_ready), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_b0", b0, 64'h0);
        check("rst_a6", a6, 64'h0);
        adc_strobe = 1'b1;
        tick();
        check("idle_sample", 64'(sample_ready), 64'd0);
        adc_strobe = 1'b0;
        tick();
        check("idle_sample2", 64'(sample_ready), 64'd0);

        for (int r = 0; r < 2; r++) begin
            start_load();
            check({lvec[r].name, "_start_ready"}, 64'(cfg_ready), 64'd1);
            send_row(lvec[r].name, lvec[r].c, lvec[r].gap, lvec[r].hold, lvec[r].old_b0);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'(svec[r].len); i++) begin
                adc_strobe = svec[r].s[i];
                tick();
                check($sformatf("%s_c%0d", svec[r].name, i), 64'(sample_ready), 64'(svec[r].e[i]));
            end
        end
        adc_strobe = 1'b0;
        tick();

        // Restart after 17 beats; the same-cycle beat with cfg_start must be dropped.
        start_load();
        for (int k = 0; k < 17; k++) send_beat(16'hFFFF);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 16'hFFFF;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_cfg_ready", 64'(cfg_ready), 64'd1);
        check("restart_coef_ready", 64'(coefficients_ready), 64'd1);
        send_row("restart", row2, 1'b0, 1'b1, lvec[1].c[0]);

`ifdef LOOKAHEAD_COEFF_CHECKSUM_EN
        begin
            logic [15:0] x;
            logic [63:0] w;
            x = 16'h0000;
            start_load();
            for (int k = 0; k < TOTAL; k++) begin
                w = lvec[0].c[k / 4];
                x = x ^ w[16*(k%4) +: 16];
                send_beat(w[16*(k%4) +: 16]);
            end
            send_beat(x ^ 16'h0001);
            check("cks_err", 64'(load_err), 64'd1);
            check("cks_no_done", 64'(load_done), 64'd0);
            check("cks_run_ready", 64'(coefficients_ready), 64'd1);
            check("cks_cfg_ready", 64'(cfg_ready), 64'd0);
            check("cks_b0_kept", b0, row2[0]);
            check("cks_b1_kept", b1, row2[1]);
            start_load();
            check("cks_err_clear", 64'(load_err), 64'd0);
            send_row("cks_reload", lvec[0].c, 1'b0, 1'b1, row2[0]);
        end
`endif

        // Mid-load reset at beat 20: asynchronous clear, then back to IDLE.
        start_load();
        for (int k = 0; k < 20; k++) send_beat(16'h5A5A);
        #2 reset = 1'b1;
        #1;
        check("arst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("arst_coef_ready", 64'(coefficients_ready), 64'd0);
        check("arst_load_done", 64'(load_done), 64'd0);
        check("arst_sample", 64'(sample_ready), 64'd0);
        check("arst_bank_or", b0 | b1 | b2 | b3 | b4 | b5 | b6 | a3 | a6, 64'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adc_strobe = 1'(i % 2 == 0);
            tick();
            check($sformatf("post_rst_sample%0d", i), 64'(sample_ready), 64'd0);
        end
        check("post_rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("post_rst_coef_ready", 64'(coefficients_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
